multi_cycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath.
- Sequences IF/ID/EX/MEM/WB per instruction from the 6-bit opcode and drives every datapath strobe and mux select.
- Generates the 2-bit ALUop consumed by the ALU-control decoder, and forwards the opcode for the I-type ALU path.
- Handshakes with unified instruction/data memory through mem_ready.

---
 rtl/mips_ctrl_pkg.sv | 71 +++++++
 rtl/ctrl_out_decode.sv | 73 +++++++
 rtl/multi_cycle_ctrl.sv | 117 +++++++++++
 tb/tb_multi_cycle_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALUop,
// mux selects, FSM states and the decoded control bundle.
package mips_ctrl_pkg;

   localparam int OPCODE_W = 6;
   localparam int ST_W     = 4;

   localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;
   localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_BNE  = 6'b000101;
   localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;
   localparam logic [OPCODE_W-1:0] OP_SLTI = 6'b001010;
   localparam logic [OPCODE_W-1:0] OP_ANDI = 6'b001100;
   localparam logic [OPCODE_W-1:0] OP_ORI  = 6'b001101;
   localparam logic [OPCODE_W-1:0] OP_XORI = 6'b001110;
   localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;

   // Must match the ALU-control decoder's interpretation.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_IOP   = 2'b11;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_4      = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   typedef enum logic [ST_W-1:0] {
      S_IF       = 4'd0,
      S_ID       = 4'd1,
      S_EX_R     = 4'd2,
      S_WB_R     = 4'd3,
      S_EX_I     = 4'd4,
      S_WB_I     = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_WB_LW    = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BR       = 4'd10,
      S_JMP      = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
   } ctrl_t;

   function automatic logic is_ialu(input logic [OPCODE_W-1:0] op);
      return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
             (op == OP_ORI)  || (op == OP_XORI);
   endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Pure combinational state-to-control decoder; fetch strobes are
// qualified by mem_ready so a stalled fetch never loads IR or PC.
module ctrl_out_decode
   import mips_ctrl_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      unique case (state)
         S_IF: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_4;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCS_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_ID: begin
            ctrl.alu_src_b = SRCB_IMM_SH;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_EX_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_WB_R: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_EX_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_IOP;
         end
         S_WB_I: ctrl.reg_write = 1'b1;
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_WB_LW: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_BR: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_B;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCS_ALUOUT;
         end
         S_JMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCS_JUMP;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Define BNE_EN to add bne decode and the branch_ne output.
module multi_cycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] opcode,
   input  logic            zero,
   input  logic            mem_ready,
   output logic            PCWrite,
   output logic            PCWriteCond,
   output logic            IorD,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            MemtoReg,
   output logic            RegDst,
   output logic            RegWrite,
   output logic            ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [1:0]      PCSource,
   output logic [1:0]      ALUop,
   output logic [OP_W-1:0] Imme,
`ifdef BNE_EN
   output logic            branch_ne,
`endif
   output logic            illegal_op
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [OP_W-1:0]    imme_q, imme_d;
   logic               illegal_q, illegal_d;
   state_t             state;
   ctrl_t              dec, ctrl;

   // The branch condition is applied in the datapath, not here.
   logic zero_unused;
   assign zero_unused = zero;

   assign state = state_t'(state_q);

   ctrl_out_decode u_dec (
      .state     (state),
      .mem_ready (mem_ready),
      .ctrl      (dec)
   );

   always_comb begin
      state_d   = S_IF;
      imme_d    = imme_q;
      illegal_d = illegal_q;
      case (state)
         S_IF:       state_d = mem_ready ? S_ID : S_IF;
         S_ID: begin
            imme_d = opcode;
            if (opcode == OP_R)                        state_d = S_EX_R;
            else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADDR;
            else if (opcode == OP_BEQ)                 state_d = S_BR;
`ifdef BNE_EN
            else if (opcode == OP_BNE)                 state_d = S_BR;
`endif
            else if (opcode == OP_J)                   state_d = S_JMP;
            else if (is_ialu(opcode))                  state_d = S_EX_I;
            else begin
               illegal_d = 1'b1;
               state_d   = S_IF;
            end
         end
         S_EX_R:     state_d = S_WB_R;
         S_EX_I:     state_d = S_WB_I;
         S_MEM_ADDR: state_d = (imme_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   state_d = mem_ready ? S_WB_LW : S_MEM_RD;
         S_MEM_WR:   state_d = mem_ready ? S_IF : S_MEM_WR;
         default:    state_d = S_IF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IF;
         imme_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         imme_q    <= imme_d;
         illegal_q <= illegal_d;
      end
   end

   // Reset kills every strobe in the same cycle, aborting any access in flight.
   always_comb ctrl = rst_n ? dec : '0;

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign IorD        = ctrl.iord;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign IRWrite     = ctrl.ir_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign RegDst      = ctrl.reg_dst;
   assign RegWrite    = ctrl.reg_write;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign PCSource    = ctrl.pc_source;
   assign ALUop       = ctrl.alu_op;
   assign Imme        = imme_q;
   assign illegal_op  = illegal_q;

`ifdef BNE_EN
   assign branch_ne = rst_n && (state == S_BR) && (imme_q == OP_BNE);
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed vector table, then random
// instruction stream checked against a per-instruction cycle model.
module tb_multi_cycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource, ALUop;
   logic [5:0] Imme;
   logic       illegal_op;
`ifdef BNE_EN
   logic       branch_ne;
`endif

   always #5 clk = ~clk;

   multi_cycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ALUop(ALUop), .Imme(Imme),
`ifdef BNE_EN
      .branch_ne(branch_ne),
`endif
      .illegal_op(illegal_op)
   );

   // {PCWrite,PCWriteCond,IorD,MemRead}_{MemWrite,IRWrite,MemtoReg,RegDst}_
   // {RegWrite,ALUSrcA,ALUSrcB}_{PCSource,ALUop}
   logic [15:0] obs;
   assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUop};

   localparam logic [15:0] O_RST  = 16'b0000_0000_0000_0000;
   localparam logic [15:0] O_IFR  = 16'b1001_0100_0001_0000;
   localparam logic [15:0] O_IFW  = 16'b0001_0000_0001_0000;
   localparam logic [15:0] O_ID   = 16'b0000_0000_0011_0000;
   localparam logic [15:0] O_EXR  = 16'b0000_0000_0100_0010;
   localparam logic [15:0] O_WBR  = 16'b0000_0001_1000_0000;
   localparam logic [15:0] O_EXI  = 16'b0000_0000_0110_0011;
   localparam logic [15:0] O_WBI  = 16'b0000_0000_1000_0000;
   localparam logic [15:0] O_MA   = 16'b0000_0000_0110_0000;
   localparam logic [15:0] O_MRD  = 16'b0011_0000_0000_0000;
   localparam logic [15:0] O_WBLW = 16'b0000_0010_1000_0000;
   localparam logic [15:0] O_MWR  = 16'b0010_1000_0000_0000;
   localparam logic [15:0] O_BR   = 16'b0100_0000_0100_0101;
   localparam logic [15:0] O_JMP  = 16'b1000_0000_0000_1000;

   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ORI = 6'b001101;
   localparam logic [5:0] BAD = 6'b111111;

   typedef struct {
      logic        rst_n;
      logic [5:0]  op;
      logic        mr;
      logic [15:0] exp;
      logic        chk_reg;
      logic        ill;
      logic [5:0]  imme;
   } vec_t;

   typedef struct {
      logic        mr;
      logic [15:0] exp;
   } cyc_t;

   vec_t tbl[$];
   cyc_t trace[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [5:0] op, input logic mr,
                      input logic [15:0] exp, input logic chk,
                      input logic ill, input logic [5:0] imme);
      vec_t v;
      v.rst_n = r; v.op = op; v.mr = mr; v.exp = exp;
      v.chk_reg = chk; v.ill = ill; v.imme = imme;
      tbl.push_back(v);
   endtask

   task automatic push(input logic mr, input logic [15:0] exp);
      cyc_t c;
      c.mr = mr; c.exp = exp;
      trace.push_back(c);
   endtask

   initial begin
      logic [5:0] legal [10];
      logic [5:0] illeg [3];
      logic [5:0] op, prev_op;
      logic       ill_m, is_ill;
      int         f, m;

      legal = '{R, LW, SW, BEQ, J, 6'b001000, 6'b001010, 6'b001100, ORI, 6'b001110};
      illeg = '{BAD, 6'b000001, 6'b010000};

      // reset, R, stalled-fetch ori, beq, j
      add(0, R,   1, O_RST,  0, 0, 0);
      add(0, R,   1, O_RST,  0, 0, 0);
      add(1, R,   1, O_IFR,  1, 0, 0);
      add(1, R,   1, O_ID,   0, 0, 0);
      add(1, R,   1, O_EXR,  1, 0, R);
      add(1, R,   1, O_WBR,  0, 0, 0);
      add(1, ORI, 0, O_IFW,  0, 0, 0);
      add(1, ORI, 1, O_IFR,  0, 0, 0);
      add(1, ORI, 1, O_ID,   0, 0, 0);
      add(1, ORI, 1, O_EXI,  1, 0, ORI);
      add(1, ORI, 1, O_WBI,  0, 0, 0);
      add(1, BEQ, 1, O_IFR,  0, 0, 0);
      add(1, BEQ, 1, O_ID,   0, 0, 0);
      add(1, BEQ, 1, O_BR,   1, 0, BEQ);
      add(1, J,   1, O_IFR,  0, 0, 0);
      add(1, J,   1, O_ID,   0, 0, 0);
      add(1, J,   1, O_JMP,  1, 0, J);
      // lw with two read stalls: 7 cycles
      add(1, LW,  1, O_IFR,  0, 0, 0);
      add(1, LW,  1, O_ID,   0, 0, 0);
      add(1, LW,  1, O_MA,   1, 0, LW);
      add(1, LW,  0, O_MRD,  0, 0, 0);
      add(1, LW,  0, O_MRD,  0, 0, 0);
      add(1, LW,  1, O_MRD,  0, 0, 0);
      add(1, LW,  1, O_WBLW, 0, 0, 0);
      add(1, SW,  1, O_IFR,  0, 0, 0);
      add(1, SW,  1, O_ID,   0, 0, 0);
      add(1, SW,  1, O_MA,   1, 0, SW);
      add(1, SW,  1, O_MWR,  0, 0, 0);
      // illegal opcode, then reset in the middle of a store
      add(1, BAD, 1, O_IFR,  0, 0, 0);
      add(1, BAD, 1, O_ID,   1, 0, SW);
      add(1, SW,  1, O_IFR,  1, 1, BAD);
      add(1, SW,  1, O_ID,   0, 0, 0);
      add(1, SW,  1, O_MA,   0, 0, 0);
      add(1, SW,  0, O_MWR,  1, 1, SW);
      add(0, SW,  0, O_RST,  1, 1, SW);
      add(0, SW,  0, O_RST,  1, 0, 0);
      add(1, R,   1, O_IFR,  1, 0, 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         rst_n = tbl[i].rst_n; opcode = tbl[i].op; mem_ready = tbl[i].mr;
         #2;
         check($sformatf("vec%0d_out", i), obs, tbl[i].exp);
         if (tbl[i].chk_reg) begin
            check($sformatf("vec%0d_illegal", i), {15'd0, illegal_op}, {15'd0, tbl[i].ill});
            check($sformatf("vec%0d_imme", i), {10'd0, Imme}, {10'd0, tbl[i].imme});
         end
      end

      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b0;

      // Random stream: each instruction expands to its expected per-cycle trace.
      ill_m = 1'b0; prev_op = '0;
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 11) < 10) op = legal[$urandom_range(0, 9)];
         else                            op = illeg[$urandom_range(0, 2)];
         f = $urandom_range(0, 2);
         m = $urandom_range(0, 2);
         is_ill = 1'b0;
         trace.delete();
         for (int k = 0; k < f; k++) push(1'b0, O_IFW);
         push(1'b1, O_IFR);
         push(1'($urandom_range(0, 1)), O_ID);
         case (op)
            R: begin
               push(1'($urandom_range(0, 1)), O_EXR);
               push(1'($urandom_range(0, 1)), O_WBR);
            end
            LW: begin
               push(1'($urandom_range(0, 1)), O_MA);
               for (int k = 0; k < m; k++) push(1'b0, O_MRD);
               push(1'b1, O_MRD);
               push(1'($urandom_range(0, 1)), O_WBLW);
            end
            SW: begin
               push(1'($urandom_range(0, 1)), O_MA);
               for (int k = 0; k < m; k++) push(1'b0, O_MWR);
               push(1'b1, O_MWR);
            end
            BEQ: push(1'($urandom_range(0, 1)), O_BR);
            J:   push(1'($urandom_range(0, 1)), O_JMP);
            6'b001000, 6'b001010, 6'b001100, ORI, 6'b001110: begin
               push(1'($urandom_range(0, 1)), O_EXI);
               push(1'($urandom_range(0, 1)), O_WBI);
            end
            default: is_ill = 1'b1;
         endcase
         foreach (trace[k]) begin
            @(negedge clk);
            rst_n = 1'b1; opcode = op; mem_ready = trace[k].mr;
            #2;
            if (k == 0) begin
               check($sformatf("rnd%0d_illegal", n), {15'd0, illegal_op}, {15'd0, ill_m});
               check($sformatf("rnd%0d_imme", n), {10'd0, Imme}, {10'd0, prev_op});
            end
            check($sformatf("rnd%0d_op%b_c%0d", n, op, k), obs, trace[k].exp);
         end
         if (is_ill) ill_m = 1'b1;
         prev_op = op;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
